alu_exec_unit: RTL and testbench
================================

Name: alu_exec_unit

Overview:
- Execute stage directly downstream of the ALU control decoder: it consumes the 3-bit ALU control code plus two operands and produces a registered result and condition flags.
- Adds/subtracts and logic ops complete in one cycle; SLL/SRL run iteratively, one bit position per cycle, to keep the barrel shifter out of the critical path.
- Uses a valid/ready handshake on both sides so hazard/stall logic can hold it.

Parameters:
- WIDTH, 32, operand/result width in bits
- SHAMT_W, 5, shift-amount width; must equal log2(WIDTH); the shift amount is B[SHAMT_W-1:0]

Ports:
- clk  input  1  clock, rising edge
- rst  input  1  reset, synchronous, active-high
- flush  input  1  synchronous kill of in-flight/held op
- in_valid  input  1  upstream op present
- in_ready  output  1  unit can accept op this cycle
- ALU_Control  input  3  000 ADD, 001 SUB, 010 AND, 011 OR, 100 XOR, 101 SLL, 110 SRL, 111 treated as ADD
- A  input  WIDTH  operand 1 (rs1)
- B  input  WIDTH  operand 2 (rs2/imm)
- out_valid  output  1  Result/flags valid
- out_ready  input  1  downstream accepts result
- Result  output  WIDTH  registered result
- Zero  output  1  Result == 0
- Negative  output  1  Result[WIDTH-1]
- Carry  output  1  ADD: carry out; SUB: 1 when A >= B unsigned (no borrow); else 0
- Overflow  output  1  signed overflow for ADD/SUB; else 0

Behaviour:
- Reset (rst=1 at clk edge): state=IDLE, out_valid=0, Result=0, Zero=1, Negative=0, Carry=0, Overflow=0. Reset dominates flush and all handshakes.
- Accept occurs when in_valid && in_ready at a rising edge. Operands and control are captured at accept; inputs are don't-care afterwards.
- in_ready = (state==IDLE) || (state==DONE && out_ready) || (state==DONE && flush==0 && out_valid==0). In practice in_ready is 0 during SHIFT.
- States:
  - IDLE: on accept of a non-shift op, compute and go to DONE with out_valid=1 next cycle (latency 1). On accept of SLL/SRL with shamt=0, same as non-shift: Result=A, latency 1. On accept of SLL/SRL with shamt>0, load working reg=A and counter=shamt, go to SHIFT.
  - SHIFT: each cycle shift the working reg by 1 (SLL: left, zero fill; SRL: logical right, zero fill) and decrement the counter. When the counter reaches 0, write Result and go to DONE. Latency = 1 + shamt cycles from accept to out_valid (shamt=31 gives 32 cycles).
  - DONE: out_valid=1; Result and flags are held stable while out_ready=0. On out_ready=1 the result is consumed. If a new accept happens in the same cycle, process it as from IDLE (back-to-back single-cycle ops give throughput 1/cycle). Otherwise go to IDLE, out_valid=0.
- Arithmetic:
  - ADD/SUB are computed on WIDTH+1 bits.
  - SUB = A + ~B + 1, so Carry=1 means no borrow.
  - Overflow: ADD = (A[msb]==B[msb]) && (R[msb]!=A[msb]); SUB = (A[msb]!=B[msb]) && (R[msb]!=A[msb]).
  - Results wrap modulo 2^WIDTH.
- Flags update only when Result is written, and always together with it.
- flush=1 (rst=0): next state IDLE, out_valid=0, any SHIFT is abandoned, and no accept occurs that cycle (in_ready forced 0 while flush=1). Result and flag registers keep their old values.
- Unused code 111 behaves exactly like ADD, including flags.
- Upper bits of B above SHAMT_W are ignored for shifts.

Test Plan:
- ADD A=0x7FFFFFFF B=0x00000001 -> 1 cycle later out_valid=1, Result=0x80000000, Negative=1, Overflow=1, Carry=0, Zero=0.
- SUB A=5 B=5 -> Result=0, Zero=1, Carry=1, Overflow=0. SUB A=0 B=1 -> Result=0xFFFFFFFF, Carry=0, Negative=1.
- SLL A=0x00000001 B=0x1F -> in_ready=0 for the shift duration, out_valid exactly 32 cycles after accept, Result=0x80000000. SRL A=0x80000000 B=4 -> Result=0x08000000 after 5 cycles. SLL with B=0x20 (shamt=0) -> Result=A after 1 cycle.
- Backpressure: AND 0xF0F0F0F0/0xFF00FF00 with out_ready=0 for 3 cycles -> Result=0xF000F000 held stable and in_ready=0. Release out_ready with a queued XOR 0xFFFFFFFF/0x0F0F0F0F -> next cycle Result=0xF0F0F0F0, no bubble.
- Flush mid-SRL (shamt=10, flush at cycle 4) -> next cycle state IDLE, out_valid=0, in_ready=1, and no result is ever presented for the flushed op.
- Reset mid-SHIFT with out_valid previously 1 -> next cycle all outputs at reset values (Zero=1) and in_ready=1.

Source files
------------

// File: rtl/alu_exec_unit.sv
// Execute stage: single-cycle add/sub/logic ops plus iterative one-bit-per-cycle shifts,
// with valid/ready handshakes on both sides and registered result and condition flags.
module alu_exec_unit #(
   parameter int unsigned WIDTH   = 32,
   parameter int unsigned SHAMT_W = 5
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             flush,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [2:0]       ALU_Control,
   input  logic [WIDTH-1:0] A,
   input  logic [WIDTH-1:0] B,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] Result,
   output logic             Zero,
   output logic             Negative,
   output logic             Carry,
   output logic             Overflow
);

   typedef enum logic [1:0] {StIdle, StShift, StDone} state_e;

   state_e             state_q;
   logic [WIDTH-1:0]   work_q;
   logic [SHAMT_W-1:0] cnt_q;
   logic               shift_left_q;

   logic               accept;
   logic               is_shift;
   logic               sub_op;
   logic [SHAMT_W-1:0] shamt;
   logic [WIDTH-1:0]   b_eff;
   logic [WIDTH:0]     sum;
   logic [WIDTH-1:0]   comb_res;
   logic               comb_c;
   logic               comb_v;
   logic [WIDTH-1:0]   work_next;

   // The last term can only matter if DONE is ever entered without a valid result.
   assign in_ready = !flush && ((state_q == StIdle) ||
                                (state_q == StDone && out_ready) ||
                                (state_q == StDone && !out_valid));
   assign accept   = in_valid && in_ready;

   always_comb begin
      shamt     = B[SHAMT_W-1:0];
      is_shift  = (ALU_Control == 3'b101) || (ALU_Control == 3'b110);
      sub_op    = (ALU_Control == 3'b001);
      b_eff     = sub_op ? ~B : B;
      sum       = {1'b0, A} + {1'b0, b_eff} + (WIDTH+1)'(sub_op);
      work_next = shift_left_q ? (work_q << 1) : (work_q >> 1);
      comb_res  = sum[WIDTH-1:0];
      comb_c    = 1'b0;
      comb_v    = 1'b0;
      case (ALU_Control)
         3'b001: begin
            comb_c = sum[WIDTH];
            comb_v = (A[WIDTH-1] != B[WIDTH-1]) && (sum[WIDTH-1] != A[WIDTH-1]);
         end
         3'b010:         comb_res = A & B;
         3'b011:         comb_res = A | B;
         3'b100:         comb_res = A ^ B;
         // Only reached with a zero shift amount; the result is A unchanged.
         3'b101, 3'b110: comb_res = A;
         default: begin
            comb_c = sum[WIDTH];
            comb_v = (A[WIDTH-1] == B[WIDTH-1]) && (sum[WIDTH-1] != A[WIDTH-1]);
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= StIdle;
         out_valid    <= 1'b0;
         Result       <= '0;
         Zero         <= 1'b1;
         Negative     <= 1'b0;
         Carry        <= 1'b0;
         Overflow     <= 1'b0;
         work_q       <= '0;
         cnt_q        <= '0;
         shift_left_q <= 1'b0;
      end else if (flush) begin
         state_q   <= StIdle;
         out_valid <= 1'b0;
      end else begin
         case (state_q)
            StShift: begin
               work_q <= work_next;
               cnt_q  <= cnt_q - SHAMT_W'(1);
               if (cnt_q == SHAMT_W'(1)) begin
                  Result    <= work_next;
                  Zero      <= (work_next == '0);
                  Negative  <= work_next[WIDTH-1];
                  Carry     <= 1'b0;
                  Overflow  <= 1'b0;
                  state_q   <= StDone;
                  out_valid <= 1'b1;
               end
            end
            default: begin
               if (accept) begin
                  if (is_shift && shamt != '0) begin
                     work_q       <= A;
                     cnt_q        <= shamt;
                     shift_left_q <= (ALU_Control == 3'b101);
                     state_q      <= StShift;
                     out_valid    <= 1'b0;
                  end else begin
                     Result    <= comb_res;
                     Zero      <= (comb_res == '0);
                     Negative  <= comb_res[WIDTH-1];
                     Carry     <= comb_c;
                     Overflow  <= comb_v;
                     state_q   <= StDone;
                     out_valid <= 1'b1;
                  end
               end else if (state_q == StDone && out_ready) begin
                  state_q   <= StIdle;
                  out_valid <= 1'b0;
               end
            end
         endcase
      end
   end

endmodule

// File: tb/tb_alu_exec_unit.sv
// Scoreboard bench for alu_exec_unit: directed corner cases plus randomized traffic with
// backpressure and flushes, checked against an arithmetic reference model.
module tb_alu_exec_unit;

   localparam longint SMAX = 64'sd2147483647;
   localparam longint SMIN = -64'sd2147483648;

   logic        clk = 1'b0;
   logic        rst, flush, in_valid, in_ready, out_valid, out_ready;
   logic        Zero, Negative, Carry, Overflow;
   logic [2:0]  ALU_Control;
   logic [31:0] A, B, Result;

   typedef struct {
      logic [31:0] res;
      logic        z, n, c, v;
      int unsigned due;
   } exp_t;

   exp_t        sb[$];
   int          compared   = 0;
   int          mismatched = 0;
   int unsigned cyc        = 0;
   bit          seen       = 0;

   alu_exec_unit #(.WIDTH(32), .SHAMT_W(5)) dut (
      .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
      .ALU_Control(ALU_Control), .A(A), .B(B), .out_valid(out_valid), .out_ready(out_ready),
      .Result(Result), .Zero(Zero), .Negative(Negative), .Carry(Carry), .Overflow(Overflow)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      compared++;
      if (act !== exp) begin
         mismatched++;
         $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   function automatic exp_t model(input logic [2:0] op, input logic [31:0] a,
                                  input logic [31:0] b);
      exp_t        e;
      longint      r;
      logic [63:0] wide;
      e.c = 1'b0;
      e.v = 1'b0;
      e.due = 0;
      case (op)
         3'd1: begin
            e.res = a - b;
            e.c   = (a >= b);
            r     = longint'($signed(a)) - longint'($signed(b));
            e.v   = (r > SMAX) || (r < SMIN);
         end
         3'd2: e.res = a & b;
         3'd3: e.res = a | b;
         3'd4: e.res = a ^ b;
         3'd5: e.res = a << b[4:0];
         3'd6: e.res = a >> b[4:0];
         default: begin
            e.res = a + b;
            wide  = 64'(a) + 64'(b);
            e.c   = wide[32];
            r     = longint'($signed(a)) + longint'($signed(b));
            e.v   = (r > SMAX) || (r < SMIN);
         end
      endcase
      e.z = (e.res == 32'd0);
      e.n = e.res[31];
      return e;
   endfunction

   // Monitor: every cycle a result is presented it must match the head of the scoreboard.
   always @(negedge clk) begin
      if (rst) begin
         sb.delete();
         seen = 0;
      end else begin
         if (out_valid) begin
            if (sb.size() == 0) begin
               compared++;
               mismatched++;
               $display("FAIL unexpected_valid: out_valid=1 Result=%0h, required no result",
                        Result);
            end else begin
               if (!seen) begin
                  chk("latency", 64'(cyc), 64'(sb[0].due));
                  seen = 1;
               end
               chk("result", 64'(Result), 64'(sb[0].res));
               chk("flags", 64'({Zero, Negative, Carry, Overflow}),
                   64'({sb[0].z, sb[0].n, sb[0].c, sb[0].v}));
               if (out_ready && !flush) begin
                  void'(sb.pop_front());
                  seen = 0;
               end
            end
         end
         if (flush) begin
            sb.delete();
            seen = 0;
         end
      end
   end

   task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                        input bit rnd);
      exp_t        e;
      int          budget = 400;
      int unsigned lat;
      flush       = 1'b0;
      in_valid    = 1'b1;
      ALU_Control = op;
      A           = a;
      B           = b;
      @(negedge clk);
      while (!in_ready && budget > 0) begin
         @(posedge clk);
         #1;
         if (rnd) out_ready = ($urandom_range(0, 3) != 0);
         budget--;
         @(negedge clk);
      end
      if (!in_ready) begin
         compared++;
         mismatched++;
         $display("FAIL accept_timeout: in_ready stuck at 0, required 1");
      end else begin
         e     = model(op, a, b);
         lat   = ((op == 3'd5 || op == 3'd6) && b[4:0] != 5'd0) ? 1 + b[4:0] : 1;
         e.due = cyc + lat;
         sb.push_back(e);
      end
      @(posedge clk);
      #1;
      in_valid    = 1'b0;
      A           = $urandom;
      B           = $urandom;
      ALU_Control = 3'($urandom);
   endtask

   task automatic wait_drain();
      int n = 0;
      while (sb.size() != 0 && n < 200) begin
         @(posedge clk);
         n++;
      end
      if (sb.size() != 0) begin
         compared++;
         mismatched++;
         $display("FAIL drain_timeout: %0d results outstanding, required 0", sb.size());
      end
      @(posedge clk);
      #1;
   endtask

   task automatic check_reset_outputs(input string tag);
      @(negedge clk);
      chk({tag, "_result"}, 64'(Result), 64'd0);
      chk({tag, "_flags"}, 64'({Zero, Negative, Carry, Overflow}), 64'(4'b1000));
      chk({tag, "_out_valid"}, 64'(out_valid), 64'd0);
      chk({tag, "_in_ready"}, 64'(in_ready), 64'd1);
   endtask

   initial begin
      #5_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [2:0]  op;
      logic [31:0] a, b;
      rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
      ALU_Control = 3'd0; A = '0; B = '0;
      repeat (2) @(posedge clk);
      #1;
      check_reset_outputs("reset");
      @(posedge clk);
      #1;
      rst = 1'b0;

      // Directed arithmetic and shift corners.
      issue(3'd0, 32'h7FFF_FFFF, 32'h0000_0001, 0);
      issue(3'd1, 32'd5, 32'd5, 0);
      issue(3'd1, 32'd0, 32'd1, 0);
      issue(3'd7, 32'hFFFF_FFFF, 32'h0000_0001, 0);
      issue(3'd5, 32'h0000_0001, 32'h0000_001F, 0);
      @(negedge clk);
      chk("in_ready_during_shift", 64'(in_ready), 64'd0);
      issue(3'd6, 32'h8000_0000, 32'd4, 0);
      issue(3'd5, 32'h1234_5678, 32'h0000_0020, 0);
      wait_drain();

      // Backpressure: held AND result, then queued XOR with no bubble.
      out_ready = 1'b0;
      issue(3'd2, 32'hF0F0_F0F0, 32'hFF00_FF00, 0);
      repeat (3) begin
         @(negedge clk);
         chk("in_ready_held", 64'(in_ready), 64'd0);
      end
      @(posedge clk);
      #1;
      out_ready = 1'b1;
      issue(3'd4, 32'hFFFF_FFFF, 32'h0F0F_0F0F, 0);
      wait_drain();

      // Flush four cycles into a 10-bit SRL; nothing may ever be presented for it.
      issue(3'd6, 32'hDEAD_BEEF, 32'd10, 0);
      repeat (3) begin
         @(posedge clk);
         #1;
      end
      flush = 1'b1;
      @(posedge clk);
      #1;
      flush = 1'b0;
      @(negedge clk);
      chk("flush_out_valid", 64'(out_valid), 64'd0);
      chk("flush_in_ready", 64'(in_ready), 64'd1);
      repeat (20) @(posedge clk);
      #1;

      // Reset in the middle of a shift after a result was presented.
      issue(3'd0, 32'd3, 32'd4, 0);
      wait_drain();
      issue(3'd5, 32'hA5A5_A5A5, 32'd20, 0);
      repeat (5) begin
         @(posedge clk);
         #1;
      end
      rst = 1'b1;
      @(posedge clk);
      #1;
      check_reset_outputs("mid_shift_reset");
      @(posedge clk);
      #1;
      rst = 1'b0;

      // Randomized traffic with random backpressure and occasional flushes.
      for (int i = 0; i < 300; i++) begin
         repeat ($urandom_range(0, 3)) begin
            @(posedge clk);
            #1;
            out_ready = ($urandom_range(0, 3) != 0);
            flush     = ($urandom_range(0, 30) == 0);
         end
         op = 3'($urandom);
         a  = $urandom;
         b  = $urandom;
         if ($urandom_range(0, 7) == 0) b = b & 32'hFFFF_FFE0;
         issue(op, a, b, 1);
      end
      @(posedge clk);
      #1;
      out_ready = 1'b1;
      flush     = 1'b0;
      wait_drain();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
